// File: rtl/myadd4.sv
// myadd4 - registered ripple-carry adder with carry-in, carry-out and
// two's-complement overflow flag.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   x, y       unsigned operands, WIDTH bits
//   cin        carry into bit 0
//   in_valid   qualifies x, y and cin this cycle
//   s          registered sum, (x + y + cin) mod 2^WIDTH
//   cout       registered carry out of the MSB
//   ovf        registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid  one-cycle strobe per accepted operand set
//
// Result is visible one cycle after the accept. Idle cycles hold the last
// result and drop out_valid.

module myadd4_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

module myadd4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_comb;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    myadd4_fa u_fa (
      .a   (x[i]),
      .b   (y[i]),
      .ci  (c[i]),
      .sum (sum_comb[i]),
      .co  (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_comb;
        cout <= c[WIDTH];
        // Signed overflow happens exactly when the carry into and out of
        // the sign bit disagree.
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_myadd4.sv
module tb_myadd4;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] x, y, s;
  logic       cin, in_valid, cout, ovf, out_valid;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  myadd4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  // Reference: unsigned sum for {cout,s}, signed range test for ovf.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic c);
    int   u;
    int   sg;
    exp_t e;
    u      = int'(a) + int'(b) + int'(c);
    sg     = int'($signed(a)) + int'($signed(b)) + int'(c);
    e.s    = u[3:0];
    e.cout = u[4];
    e.ovf  = (sg > 7) || (sg < -8);
    return e;
  endfunction

  // Drive one operand set; accepted sets go to the scoreboard.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    x        = a;
    y        = b;
    cin      = c;
    in_valid = v;
    if (v && rst_n) sb.push_back(model(a, b, c));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    apply(4'd15, 4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({out_valid, cout, ovf, s} !== 7'b0) begin
        n_err++;
        $display("FAIL reset[%0d] got valid=%b cout=%b ovf=%b s=%0d want all 0",
                 i, out_valid, cout, ovf, s);
      end
    end
    rst_n = 1'b1;
    apply(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_directed(input logic c);
    logic [3:0] xa [4];
    logic [3:0] ya [4];
    exp_t e;
    if (c == 1'b0) begin
      xa = '{4'd0, 4'd1, 4'd2, 4'd15};
      ya = '{4'd0, 4'd5, 4'd8, 4'd15};
    end else begin
      xa = '{4'd1, 4'd2, 4'd4, 4'd11};
      ya = '{4'd5, 4'd8, 4'd7, 4'd4};
    end
    for (int i = 0; i < 4; i++) begin
      apply(xa[i], ya[i], c, 1'b1);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL directed_cin%0d_valid[%0d] got %b want 1", c, i, out_valid);
      end
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL directed_cin%0d_sb[%0d] got empty scoreboard want entry", c, i);
      end else begin
        e = sb.pop_front();
        if ({cout, s, ovf} !== {e.cout, e.s, e.ovf}) begin
          n_err++;
          $display("FAIL directed_cin%0d[%0d] %0d+%0d got cout=%b s=%0d ovf=%b want cout=%b s=%0d ovf=%b",
                   c, i, xa[i], ya[i], cout, s, ovf, e.cout, e.s, e.ovf);
        end
      end
    end
    apply(4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_hold;
    exp_t e;
    apply(4'd2, 4'd8, 1'b1, 1'b1);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL hold_accept got out_valid=%b sb=%0d want 1 and entry", out_valid, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      last_exp = e;
      n_vec++;
      if ({cout, s, ovf} !== {e.cout, e.s, e.ovf}) begin
        n_err++;
        $display("FAIL hold_result got cout=%b s=%0d ovf=%b want cout=%b s=%0d ovf=%b",
                 cout, s, ovf, e.cout, e.s, e.ovf);
      end
    end
    apply(4'd15, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || {cout, s, ovf} !== {last_exp.cout, last_exp.s, last_exp.ovf}) begin
        n_err++;
        $display("FAIL hold_idle[%0d] got valid=%b cout=%b s=%0d ovf=%b want valid=0 cout=%b s=%0d ovf=%b",
                 i, out_valid, cout, s, ovf, last_exp.cout, last_exp.s, last_exp.ovf);
      end
    end
  endtask

  task automatic test_exhaustive;
    exp_t e;
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      apply(v[3:0], v[7:4], v[8], 1'b1);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        n_err++;
        $display("FAIL exhaustive_valid[%0d] got out_valid=%b sb=%0d want 1 and entry",
                 i, out_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if ({cout, s, ovf} !== {e.cout, e.s, e.ovf}) begin
          n_err++;
          $display("FAIL exhaustive[%0d] %0d+%0d+%0d got cout=%b s=%0d ovf=%b want cout=%b s=%0d ovf=%b",
                   i, v[3:0], v[7:4], v[8], cout, s, ovf, e.cout, e.s, e.ovf);
        end
      end
    end
    apply(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL exhaustive_tail got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_collision;
    exp_t e;
    rst_n = 1'b0;
    apply(4'd7, 4'd9, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({out_valid, cout, ovf, s} !== 7'b0) begin
      n_err++;
      $display("FAIL collision got valid=%b cout=%b ovf=%b s=%0d want all 0",
               out_valid, cout, ovf, s);
    end
    rst_n = 1'b1;
    apply(4'd3, 4'd4, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL collision_recover_valid got out_valid=%b sb=%0d want 1 and entry",
               out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({cout, s, ovf} !== {e.cout, e.s, e.ovf}) begin
        n_err++;
        $display("FAIL collision_recover got cout=%b s=%0d ovf=%b want cout=%b s=%0d ovf=%b",
                 cout, s, ovf, e.cout, e.s, e.ovf);
      end
    end
    apply(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL collision_tail got out_valid=%b want 0", out_valid);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    x        = '0;
    y        = '0;
    cin      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed(1'b0);
    test_directed(1'b1);
    test_hold();
    test_exhaustive();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
